// File: rtl/fpu_wb_sched_pkg.sv
// Shared FPU writeback-scheduler constants: op class encodings, default pipe
// latencies and reservation-table depth.
package fpu_wb_sched_pkg;
    typedef logic [1:0] cls_t;

    localparam cls_t CLS_RECODE = 2'd0;
    localparam cls_t CLS_CVT    = 2'd1;
    localparam cls_t CLS_ADD    = 2'd2;
    localparam cls_t CLS_MUL    = 2'd3;

    localparam int LAT0_DEF  = 1;
    localparam int LAT1_DEF  = 2;
    localparam int LAT2_DEF  = 4;
    localparam int LAT3_DEF  = 6;
    localparam int TBL_DEPTH = 8;
endpackage

// File: rtl/fpu_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when something is granted.
module fpu_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);
    logic r_ptr;  // 1 = requester 1 wins a tie

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11)
            grant = r_ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (|grant)
            r_ptr <= grant[0];
    end
endmodule

// File: rtl/fpu_wb_sched.sv
// FPU writeback scheduler: reserves the shared writeback slot L cycles ahead
// so ops of different latency never collide on the single result port.
module fpu_wb_sched
    import fpu_wb_sched_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int LAT0  = LAT0_DEF,
    parameter int LAT1  = LAT1_DEF,
    parameter int LAT2  = LAT2_DEF,
    parameter int LAT3  = LAT3_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [1:0]         req_valid,
    input  logic [3:0]         req_class,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic [1:0]         req_ready,
    output logic               issue_valid,
    output logic               issue_src,
    output logic [1:0]         issue_class,
    output logic [TAG_W-1:0]   issue_tag,
    output logic               wb_valid,
    output logic [TAG_W-1:0]   wb_tag,
    output logic [1:0]         wb_class,
    output logic [3:0]         inflight,
    output logic               busy
);
    logic [TBL_DEPTH-1:0]            r_vld;
    logic [TBL_DEPTH-1:0][TAG_W-1:0] r_tag;
    logic [TBL_DEPTH-1:0][1:0]       r_cls;
    logic [3:0]                      r_inflight;

    logic [TBL_DEPTH:0]    w_vld_ext;
    logic [1:0][1:0]       w_cls;
    logic [1:0][3:0]       w_lat;
    logic [1:0]            w_elig;
    logic [1:0]            w_grant;
    logic [3:0]            w_lat_g;
    logic [2:0]            w_wr_idx;

    function automatic logic [3:0] lat_of(input cls_t c);
        case (c)
            CLS_RECODE: lat_of = 4'(LAT0);
            CLS_CVT:    lat_of = 4'(LAT1);
            CLS_ADD:    lat_of = 4'(LAT2);
            CLS_MUL:    lat_of = 4'(LAT3);
            default:    lat_of = 4'(LAT0);
        endcase
    endfunction

    // slot[8] is a permanently empty entry so LAT=8 can be checked uniformly
    assign w_vld_ext = {1'b0, r_vld};

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            w_cls[r]  = req_class[2*r +: 2];
            w_lat[r]  = lat_of(w_cls[r]);
            w_elig[r] = req_valid[r] & ~w_vld_ext[w_lat[r]] & ~flush & ~reset;
        end
    end

    fpu_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (w_elig),
        .grant    (w_grant)
    );

    assign req_ready   = w_grant;
    assign issue_valid = |w_grant;
    assign issue_src   = w_grant[1];
    assign issue_class = w_grant[1] ? w_cls[1] : (w_grant[0] ? w_cls[0] : 2'd0);
    assign issue_tag   = w_grant[1] ? req_tag[TAG_W +: TAG_W]
                       : (w_grant[0] ? req_tag[0 +: TAG_W] : '0);
    assign w_lat_g     = w_grant[1] ? w_lat[1] : w_lat[0];
    // The op lands one below its checked slot because the table shifts on the same edge
    assign w_wr_idx    = 3'(w_lat_g - 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld      <= '0;
            r_tag      <= '0;
            r_cls      <= '0;
            r_inflight <= '0;
        end else if (flush) begin
            r_vld      <= '0;
            r_inflight <= '0;
        end else begin
            for (int k = 0; k < TBL_DEPTH; k++)
                r_vld[k] <= w_vld_ext[k+1];
            for (int k = 0; k < TBL_DEPTH - 1; k++) begin
                r_tag[k] <= r_tag[k+1];
                r_cls[k] <= r_cls[k+1];
            end
            r_tag[TBL_DEPTH-1] <= '0;
            r_cls[TBL_DEPTH-1] <= '0;
            if (issue_valid) begin
                r_vld[w_wr_idx] <= 1'b1;
                r_tag[w_wr_idx] <= issue_tag;
                r_cls[w_wr_idx] <= issue_class;
            end
            r_inflight <= r_inflight + {3'd0, issue_valid} - {3'd0, r_vld[0]};
        end
    end

    assign wb_valid = r_vld[0];
    assign wb_tag   = r_tag[0];
    assign wb_class = r_cls[0];
    assign inflight = r_inflight;
    assign busy     = (r_inflight != 4'd0);
endmodule

// File: tb/tb_fpu_wb_sched.sv
// Directed bench for fpu_wb_sched: latency, hazard stall, round-robin,
// flush and asynchronous reset scenarios with hand-computed expectations.
module tb_fpu_wb_sched;
    localparam int TAG_W = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic [1:0]         req_valid;
    logic [3:0]         req_class;
    logic [2*TAG_W-1:0] req_tag;
    logic [1:0]         req_ready;
    logic               issue_valid;
    logic               issue_src;
    logic [1:0]         issue_class;
    logic [TAG_W-1:0]   issue_tag;
    logic               wb_valid;
    logic [TAG_W-1:0]   wb_tag;
    logic [1:0]         wb_class;
    logic [3:0]         inflight;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_wb_sched #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_class   (req_class),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_src   (issue_src),
        .issue_class (issue_class),
        .issue_tag   (issue_tag),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_class    (wb_class),
        .inflight    (inflight),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] c1, input logic [1:0] c0,
                       input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t0);
        req_valid = v;
        req_class = {c1, c0};
        req_tag   = {t1, t0};
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drv(2'b11, 2'd0, 2'd0, 5'd1, 5'd2);
        tick();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_issue", issue_valid, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inflight", inflight, 0);
        drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        reset = 1'b0;

        // r0 add (lat 4) alone: writeback exactly 4 cycles later
        tick(); drv(2'b01, 2'd0, 2'd2, 5'd0, 5'd3);
        chk("a_ready", req_ready, 2'b01);
        chk("a_src", issue_src, 0);
        chk("a_class", issue_class, 2);
        chk("a_tag", issue_tag, 3);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        chk("a_idle_class", issue_class, 0);
        chk("a_idle_tag", issue_tag, 0);
        chk("a_inflight1", inflight, 1);
        chk("a_busy1", busy, 1);
        chk("a_wb_c1", wb_valid, 0);
        tick(); chk("a_wb_c2", wb_valid, 0);
        tick(); chk("a_wb_c3", wb_valid, 0);
        tick();
        chk("a_wb_c4", wb_valid, 1);
        chk("a_wbtag_c4", wb_tag, 3);
        chk("a_wbcls_c4", wb_class, 2);
        tick();
        chk("a_wb_c5", wb_valid, 0);
        chk("a_inflight0", inflight, 0);
        chk("a_busy0", busy, 0);

        // mul on r0 then convert on r1 colliding with its slot
        tick(); drv(2'b01, 2'd0, 2'd3, 5'd0, 5'd7);
        chk("b_ready0", req_ready, 2'b01);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        tick(); tick();
        tick(); drv(2'b10, 2'd1, 2'd0, 5'd9, 5'd0);
        chk("b_stall", req_ready, 2'b00);
        chk("b_stall_iv", issue_valid, 0);
        tick();
        chk("b_grant5", req_ready, 2'b10);
        chk("b_tag5", issue_tag, 9);
        chk("b_src5", issue_src, 1);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        chk("b_wb6", wb_valid, 1);
        chk("b_wbtag6", wb_tag, 7);
        chk("b_wbcls6", wb_class, 3);
        chk("b_inflight6", inflight, 2);
        tick();
        chk("b_wb7", wb_valid, 1);
        chk("b_wbtag7", wb_tag, 9);
        chk("b_wbcls7", wb_class, 1);
        tick();
        chk("b_wb8", wb_valid, 0);
        chk("b_inflight8", inflight, 0);

        // both requesters recode every cycle: strict alternation
        for (int k = 0; k < 4; k++) begin
            tick(); drv(2'b11, 2'd0, 2'd0, 5'd2, 5'd1);
            chk("c_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            chk("c_wb", wb_valid, (k > 0) ? 1 : 0);
            if (k > 0) chk("c_wbtag", wb_tag, (k % 2) ? 1 : 2);
        end
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        chk("c_wbtag4", wb_tag, 2);
        chk("c_inflight4", inflight, 1);
        tick(); chk("c_wb5", wb_valid, 0);

        // r0 blocked by a mul reservation, r1 takes the cycle
        tick(); drv(2'b01, 2'd0, 2'd3, 5'd0, 5'd4);
        chk("d_ready0", req_ready, 2'b01);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        tick(); drv(2'b11, 2'd0, 2'd2, 5'd5, 5'd8);
        chk("d_bypass", req_ready, 2'b10);
        chk("d_bypass_tag", issue_tag, 5);
        tick(); drv(2'b11, 2'd0, 2'd0, 5'd7, 5'd6);
        chk("d_ptr_r0", req_ready, 2'b01);
        chk("d_wbtag3", wb_tag, 5);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        chk("d_wbtag4", wb_tag, 6);
        tick();
        chk("d_wb5", wb_valid, 0);
        tick();
        chk("d_wbtag6", wb_tag, 4);
        chk("d_wbcls6", wb_class, 3);
        tick(); chk("d_inflight7", inflight, 0);

        // three muls in flight, then flush
        tick(); drv(2'b01, 2'd0, 2'd3, 5'd0, 5'd10);
        chk("e_ready0", req_ready, 2'b01);
        tick(); drv(2'b10, 2'd3, 2'd0, 5'd11, 5'd0);
        chk("e_ready1", req_ready, 2'b10);
        tick(); drv(2'b01, 2'd0, 2'd3, 5'd0, 5'd12);
        chk("e_ready2", req_ready, 2'b01);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        chk("e_inflight3", inflight, 3);
        tick();
        tick(); flush = 1'b1; drv(2'b11, 2'd0, 2'd0, 5'd14, 5'd13);
        chk("e_flush_ready", req_ready, 2'b00);
        chk("e_flush_iv", issue_valid, 0);
        tick(); flush = 1'b0; drv(2'b11, 2'd0, 2'd0, 5'd14, 5'd13);
        chk("e_wb6", wb_valid, 0);
        chk("e_inflight6", inflight, 0);
        chk("e_busy6", busy, 0);
        chk("e_ptr_kept", req_ready, 2'b10);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        chk("e_wbtag7", wb_tag, 14);
        tick(); chk("e_wb8", wb_valid, 0);
        tick(); chk("e_wb9", wb_valid, 0);

        // async reset mid-cycle with two muls in flight
        tick(); drv(2'b01, 2'd0, 2'd3, 5'd0, 5'd20);
        chk("f_ready0", req_ready, 2'b01);
        tick(); drv(2'b01, 2'd0, 2'd3, 5'd0, 5'd21);
        chk("f_ready1", req_ready, 2'b01);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        chk("f_inflight2", inflight, 2);
        #1 reset = 1'b1;
        drv(2'b11, 2'd0, 2'd0, 5'd1, 5'd2);
        chk("f_rst_inflight", inflight, 0);
        chk("f_rst_busy", busy, 0);
        chk("f_rst_wb", wb_valid, 0);
        chk("f_rst_ready", req_ready, 2'b00);
        tick();
        drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("f_post_wb", wb_valid, 0);
        end
        chk("f_post_inflight", inflight, 0);
        tick(); drv(2'b11, 2'd0, 2'd0, 5'd2, 5'd1);
        chk("f_ptr_reset", req_ready, 2'b01);
        tick(); drv(2'b00, 2'd0, 2'd0, 5'd0, 5'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
